// File: rtl/riscv_com_rob.sv
// riscv_com_rob: in-order commit buffer with out-of-order writeback by tag.
// Retires up to COMMIT_W completed entries per cycle to register-file lanes;
// a faulting head entry raises com_exc and clears the buffer like a flush.
// Optional retired-instruction counter under `RISCV_COM_PERF_CNT_EN.
module riscv_com_rob #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int AREG_W   = 5,
  parameter int TAG_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_valid,
  input  logic [AREG_W-1:0]            alloc_rd_addr,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic                         wb_valid,
  input  logic [TAG_W-1:0]             wb_tag,
  input  logic [XLEN-1:0]              wb_data,
  input  logic                         wb_exc,
  input  logic                         flush,
  output logic [COMMIT_W-1:0]          rf_wen,
  output logic [COMMIT_W*AREG_W-1:0]   rf_waddr,
  output logic [COMMIT_W*XLEN-1:0]     rf_wdata,
  output logic [COMMIT_W-1:0]          com_valid,
  output logic                         com_exc,
  output logic [TAG_W-1:0]             com_exc_tag,
`ifdef RISCV_COM_PERF_CNT_EN
  output logic [63:0]                  retired_cnt,
`endif
  output logic [TAG_W:0]               rob_count
);

  localparam int PW = TAG_W + 1;

  logic [PW-1:0]       head, tail, count;
  logic [PW-1:0]       head_n, tail_n, count_n;
  logic [DEPTH-1:0]    busy, done, busy_n, done_n;
  logic [DEPTH-1:0]    exc_q;
  logic [AREG_W-1:0]   rd_q   [DEPTH];
  logic [XLEN-1:0]     data_q [DEPTH];

  logic [TAG_W-1:0]    lane_idx [COMMIT_W];
  logic [COMMIT_W-1:0] elig;
  logic [PW-1:0]       nret;
  logic                chain;
  logic                exc_head, alloc_fire, wb_fire;
  logic [COMMIT_W-1:0] rf_wen_n, com_valid_n;

  assign alloc_ready = (count != PW'(DEPTH));
  assign alloc_tag   = tail[TAG_W-1:0];
  assign rob_count   = count;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign wb_fire     = wb_valid && busy[wb_tag] && !done[wb_tag];
  assign exc_head    = busy[head[TAG_W-1:0]] && done[head[TAG_W-1:0]] &&
                       exc_q[head[TAG_W-1:0]];

  // Retire eligibility: contiguous run of clean completed entries from head
  always_comb begin
    elig  = '0;
    nret  = '0;
    chain = 1'b1;
    for (int unsigned i = 0; i < COMMIT_W; i++) begin
      lane_idx[i] = head[TAG_W-1:0] + TAG_W'(i);
      chain = chain && busy[lane_idx[i]] && done[lane_idx[i]] && !exc_q[lane_idx[i]];
      elig[i] = chain;
      nret = nret + PW'(chain);
    end
  end

  // Next control state: flush beats head exception beats normal operation
  always_comb begin
    busy_n      = busy;
    done_n      = done;
    head_n      = head;
    tail_n      = tail;
    count_n     = count;
    rf_wen_n    = '0;
    com_valid_n = '0;
    if (flush || exc_head) begin
      busy_n  = '0;
      done_n  = '0;
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end else begin
      for (int unsigned i = 0; i < COMMIT_W; i++) begin
        if (elig[i]) begin
          busy_n[lane_idx[i]] = 1'b0;
          done_n[lane_idx[i]] = 1'b0;
          com_valid_n[i]      = 1'b1;
          rf_wen_n[i]         = (rd_q[lane_idx[i]] != '0);
        end
      end
      // retiring entries are already done, so a writeback never hits them
      if (wb_fire) done_n[wb_tag] = 1'b1;
      if (alloc_fire) begin
        busy_n[tail[TAG_W-1:0]] = 1'b1;
        done_n[tail[TAG_W-1:0]] = 1'b0;
        tail_n = tail + PW'(1);
      end
      head_n  = head + nret;
      count_n = count + PW'(alloc_fire) - nret;
    end
  end

  // Control state and control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      done      <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rf_wen    <= '0;
      com_valid <= '0;
      com_exc   <= 1'b0;
    end else begin
      busy      <= busy_n;
      done      <= done_n;
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      rf_wen    <= rf_wen_n;
      com_valid <= com_valid_n;
      com_exc   <= exc_head && !flush;
    end
  end

  // Entry payload and datapath outputs (no reset)
  always_ff @(posedge clk) begin
    if (!flush && !exc_head) begin
      if (alloc_fire) begin
        rd_q[tail[TAG_W-1:0]]  <= alloc_rd_addr;
        exc_q[tail[TAG_W-1:0]] <= 1'b0;
      end
      if (wb_fire) begin
        data_q[wb_tag] <= wb_data;
        exc_q[wb_tag]  <= wb_exc;
      end
      for (int unsigned i = 0; i < COMMIT_W; i++) begin
        if (elig[i]) begin
          rf_waddr[i*AREG_W +: AREG_W] <= rd_q[lane_idx[i]];
          rf_wdata[i*XLEN +: XLEN]     <= data_q[lane_idx[i]];
        end
      end
    end
    if (exc_head && !flush) com_exc_tag <= head[TAG_W-1:0];
  end

`ifdef RISCV_COM_PERF_CNT_EN
  logic [64:0] cnt_sum;
  logic [PW-1:0] cv_pop;

  // Saturating sum of lanes retired in the previous cycle
  always_comb begin
    cv_pop = '0;
    for (int unsigned i = 0; i < COMMIT_W; i++) cv_pop = cv_pop + PW'(com_valid[i]);
    cnt_sum = {1'b0, retired_cnt} + 65'(cv_pop);
  end

  // Retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retired_cnt <= '0;
    else if (cnt_sum[64]) retired_cnt <= '1;
    else                 retired_cnt <= cnt_sum[63:0];
  end
`endif

endmodule

// File: tb/tb_riscv_com_rob.sv
// Self-checking bench for riscv_com_rob: directed scenarios plus random
// traffic, all compared against a queue-based program-order model.
module tb_riscv_com_rob;
  localparam int XLEN = 32, DEPTH = 16, CW = 2, AW = 5, TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alloc_valid;
  logic [AW-1:0]   alloc_rd_addr;
  logic            alloc_ready;
  logic [TW-1:0]   alloc_tag;
  logic            wb_valid;
  logic [TW-1:0]   wb_tag;
  logic [XLEN-1:0] wb_data;
  logic            wb_exc;
  logic            flush;
  logic [CW-1:0]   rf_wen;
  logic [CW*AW-1:0]   rf_waddr;
  logic [CW*XLEN-1:0] rf_wdata;
  logic [CW-1:0]   com_valid;
  logic            com_exc;
  logic [TW-1:0]   com_exc_tag;
  logic [TW:0]     rob_count;
`ifdef RISCV_COM_PERF_CNT_EN
  logic [63:0]     retired_cnt;
`endif

  riscv_com_rob #(.XLEN(XLEN), .DEPTH(DEPTH), .COMMIT_W(CW), .AREG_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_rd_addr(alloc_rd_addr),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc),
    .flush(flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .com_valid(com_valid), .com_exc(com_exc), .com_exc_tag(com_exc_tag),
`ifdef RISCV_COM_PERF_CNT_EN
    .retired_cnt(retired_cnt),
`endif
    .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program-order queue of in-flight instructions
  typedef struct {
    int          tag;
    logic [AW-1:0] rd;
    bit          done;
    bit          exc;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  bit [CW-1:0] e_cv, e_wen;
  logic [AW-1:0]   e_wa [CW];
  logic [XLEN-1:0] e_wd [CW];
  bit   e_exc;
  int   e_etag;
  longint unsigned e_cnt;

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_rd_addr = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0; wb_exc = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    q.delete(); m_tail = 0;
    e_cv = '0; e_wen = '0; e_exc = 0; e_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_com_valid", com_valid, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_com_exc", com_exc, 0);
    check("rst_rob_count", rob_count, 0);
    check("rst_alloc_ready", alloc_ready, 1);
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic tick();
    int n;
    bit ready;
    ent_t e;
    check("alloc_ready", alloc_ready, (q.size() != DEPTH) ? 1 : 0);
    check("alloc_tag", alloc_tag, m_tail);
    check("rob_count", rob_count, q.size());
    e_cnt += $countones(e_cv);
    e_cv = '0; e_wen = '0; e_exc = 0;
    if (flush) begin
      q.delete(); m_tail = 0;
    end else if (q.size() > 0 && q[0].done && q[0].exc) begin
      e_exc = 1; e_etag = q[0].tag;
      q.delete(); m_tail = 0;
    end else begin
      ready = (q.size() != DEPTH);
      n = 0;
      while (n < CW && n < q.size() && q[n].done && !q[n].exc) begin
        e_cv[n] = 1; e_wen[n] = (q[n].rd != 0);
        e_wa[n] = q[n].rd; e_wd[n] = q[n].data;
        n++;
      end
      if (wb_valid) begin
        for (int j = 0; j < q.size(); j++) begin
          if (q[j].tag == int'(wb_tag) && !q[j].done) begin
            e = q[j]; e.done = 1; e.exc = wb_exc; e.data = wb_data; q[j] = e;
          end
        end
      end
      repeat (n) void'(q.pop_front());
      if (alloc_valid && ready) begin
        e.tag = m_tail; e.rd = alloc_rd_addr; e.done = 0; e.exc = 0; e.data = 'x;
        q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk); #1;
    check("com_valid", com_valid, e_cv);
    check("rf_wen", rf_wen, e_wen);
    check("com_exc", com_exc, e_exc);
    if (e_exc) check("com_exc_tag", com_exc_tag, e_etag);
    for (int i = 0; i < CW; i++) begin
      if (e_cv[i]) begin
        check("rf_waddr", rf_waddr[i*AW +: AW], e_wa[i]);
        check("rf_wdata", rf_wdata[i*XLEN +: XLEN], e_wd[i]);
      end
    end
`ifdef RISCV_COM_PERF_CNT_EN
    check("retired_cnt", retired_cnt, e_cnt);
`endif
  endtask

  task automatic alloc1(input logic [AW-1:0] rd);
    idle_inputs(); alloc_valid = 1'b1; alloc_rd_addr = rd; tick();
  endtask

  task automatic wb1(input int tag, input logic [XLEN-1:0] d, input bit ex);
    idle_inputs(); wb_valid = 1'b1; wb_tag = TW'(tag); wb_data = d; wb_exc = ex; tick();
  endtask

  initial begin
    int t;
    // Fill: 16 allocs, rd = 1..16
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc1(AW'(i + 1));
    check("full_count", rob_count, 16);
    check("full_ready", alloc_ready, 0);
    alloc1(5'd20);
    check("full_no_alloc", rob_count, 16);
    // Out-of-order writebacks 3,2,1,0
    for (int i = 3; i >= 0; i--) begin
      wb1(i, 32'hA0 + i, 0);
      check("no_early_retire", com_valid, 0);
    end
    idle_inputs(); tick();
    check("ret01_valid", com_valid, 2'b11);
    check("ret01_d0", rf_wdata[31:0], 32'hA0);
    check("ret01_d1", rf_wdata[63:32], 32'hA1);
    tick();
    check("ret23_valid", com_valid, 2'b11);
    check("ret23_d0", rf_wdata[31:0], 32'hA2);
    check("ret23_a1", rf_waddr[9:5], 5'd4);
    repeat (2) tick();

    // x0 destination retires without a write
    do_reset();
    alloc1(5'd0);
    wb1(0, 32'h55, 0);
    idle_inputs(); tick();
    check("x0_valid", com_valid, 2'b01);
    check("x0_wen", rf_wen, 2'b00);
    check("x0_count", rob_count, 0);

    // Precise exception on tag 1
    do_reset();
    alloc1(5'd1); alloc1(5'd2); alloc1(5'd3);
    wb1(1, 32'h11, 1);
    wb1(0, 32'h10, 0);
    wb1(2, 32'h12, 0);
    check("exc_t0_retire", com_valid, 2'b01);
    idle_inputs(); tick();
    check("exc_flag", com_exc, 1);
    check("exc_tag", com_exc_tag, 1);
    check("exc_count", rob_count, 0);
    repeat (3) begin tick(); check("exc_no_t2", com_valid, 0); end

    // Flush with concurrent alloc and head writeback
    do_reset();
    alloc1(5'd7); alloc1(5'd8);
    idle_inputs(); flush = 1'b1; alloc_valid = 1'b1; alloc_rd_addr = 5'd9;
    wb_valid = 1'b1; wb_tag = '0; wb_data = 32'hDEAD; tick();
    check("flush_count", rob_count, 0);
    check("flush_cv", com_valid, 0);
    check("flush_tag", alloc_tag, 0);
    idle_inputs(); repeat (2) tick();

    // 40 alloc/retire pairs wrapping the tail
    do_reset();
    for (int i = 0; i < 40; i++) begin
      t = m_tail;
      alloc1(AW'((i % 31) + 1));
      wb1(t, 32'h1000 + i, 0);
    end
    idle_inputs(); repeat (2) tick();
    check("wrap_count", rob_count, 0);
`ifdef RISCV_COM_PERF_CNT_EN
    check("wrap_retired", retired_cnt, 40);
`endif

    // Random traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      idle_inputs();
      alloc_valid = ($urandom_range(0, 9) < 7);
      alloc_rd_addr = AW'($urandom);
      wb_valid = ($urandom_range(0, 9) < 7);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        wb_tag = TW'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        wb_tag = TW'($urandom);
      wb_data = $urandom;
      wb_exc = ($urandom_range(0, 15) == 0);
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
